// File: rtl/apb_master_bridge.sv
// APB requester: queues read/write commands in a small FIFO and issues each as a
// SETUP/ACCESS transfer, returning one in-order response per command (data or timeout).
module apb_master_bridge #(
    parameter int DATAWIDTH  = 32,
    parameter int ADDRWIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0] PWDATA,
    input  logic [DATAWIDTH-1:0] PRDATA,
    input  logic                 PREADY
);

    localparam int PTRW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW  = $clog2(FIFO_DEPTH + 1);
    localparam int WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0]  DEPTH_C   = CNTW'(FIFO_DEPTH);
    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNTW-1:0]        count_q, count_d;
    logic [PTRW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [WAITW-1:0]       wait_q, wait_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
    logic [DATAWIDTH-1:0]   pwdata_q, pwdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                   fifo_write_q [FIFO_DEPTH];
    logic [ADDRWIDTH-1:0]   fifo_addr_q  [FIFO_DEPTH];
    logic [DATAWIDTH-1:0]   fifo_wdata_q [FIFO_DEPTH];

    logic push_s;
    logic pop_s;

    // Space is judged from the registered count only, so a same-cycle pop never frees a slot.
    assign cmd_ready = PRESETn & (count_q < DEPTH_C);
    assign push_s    = cmd_valid & cmd_ready;

    // Command storage; contents need no reset because count gates every read.
    always_ff @(posedge PCLK) begin
        if (push_s) begin
            fifo_write_q[wr_ptr_q] <= cmd_write;
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Transfer sequencer: next state, APB outputs and response generation.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_s     = 1'b1;
                    pwrite_d  = fifo_write_q[rd_ptr_q];
                    paddr_d   = fifo_addr_q[rd_ptr_q];
                    pwdata_d  = fifo_write_q[rd_ptr_q] ? fifo_wdata_q[rd_ptr_q] : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d      = wait_q + WAITW'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wait_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wait_q      <= wait_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != ST_IDLE) | (count_q != '0);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reset, write, waited read, FIFO fill,
// timeout and mid-transfer reset scenarios with hand-computed expectations.
module tb_apb_master_bridge;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    logic        echo_mode;
    logic [31:0] prdata_val;

    int checks = 0;
    int errors = 0;

    // Response log and APB activity counters, sampled on the falling edge.
    logic [32:0] rsp_log [$];
    int psel_cnt    = 0;
    int penable_cnt = 0;

    apb_master_bridge dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    // Slave model: in echo mode read data encodes the address so ordering is visible.
    assign PRDATA = echo_mode ? {24'h5A5A5A, PADDR} : prdata_val;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) rsp_log.push_back({rsp_err, rsp_rdata});
        if (PSEL === 1'b1) psel_cnt++;
        if (PENABLE === 1'b1) penable_cnt++;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        int base_psel;
        PRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 8'h55; cmd_wdata = 32'h1234_5678;
        tick(); tick();
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, busy, cmd_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, busy, cmd_ready});
        end
        checks++;
        if ({PADDR, PWDATA, rsp_rdata} !== 72'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {PADDR, PWDATA, rsp_rdata});
        end
        cmd_valid = 1'b0; PRESETn = 1'b1;
        base_psel = psel_cnt;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (psel_cnt - base_psel !== 0 || busy !== 1'b0 || rsp_log.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_xfer: got psel=%0d busy=%b rsp=%0d expected 0 0 0",
                     psel_cnt - base_psel, busy, rsp_log.size());
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int base_psel, base_pen, base_rsp;
        base_psel = psel_cnt; base_pen = penable_cnt; base_rsp = rsp_log.size();
        PREADY = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 8'h10 || PWDATA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_setup: got sel/en/wr=%b addr=%h data=%h expected 101 10 deadbeef",
                     {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
        end
        tick();
        checks++;
        if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_access: got sel/en=%b rsp=%b expected 11 0", {PSEL, PENABLE}, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp: got v=%b e=%b d=%h sel=%b expected 1 0 0 0",
                     rsp_valid, rsp_err, rsp_rdata, PSEL);
        end
        tick();
        checks++;
        if (psel_cnt - base_psel !== 2 || penable_cnt - base_pen !== 1 ||
            rsp_log.size() - base_rsp !== 1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_counts: got psel=%0d pen=%0d rsp=%0d v=%b expected 2 1 1 0",
                     psel_cnt - base_psel, penable_cnt - base_pen, rsp_log.size() - base_rsp, rsp_valid);
        end
        checks++;
        if (PADDR !== 8'h10 || PWDATA !== 32'hDEAD_BEEF || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_hold: got addr=%h data=%h busy=%b expected 10 deadbeef 0",
                     PADDR, PWDATA, busy);
        end
        PREADY = 1'b0;
    endtask

    task automatic test_read_wait();
        int acc;
        PREADY = 1'b0; echo_mode = 1'b0; prdata_val = 32'hFFFF_FFFF;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h22; cmd_wdata = 32'h1111_1111;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 8'h22 || PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL read_setup: got sel/en/wr=%b addr=%h data=%h expected 100 22 0",
                     {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
        end
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (PENABLE === 1'b1 && rsp_valid === 1'b0) acc++;
            if (i == 3) begin
                PREADY = 1'b1; prdata_val = 32'hA5A5_0001;
            end
        end
        tick();
        PREADY = 1'b0; prdata_val = 32'h0BAD_0BAD;
        checks++;
        if (acc !== 4) begin
            errors++;
            $display("FAIL read_access_len: got %0d expected 4", acc);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL read_rsp: got v=%b e=%b d=%h expected 1 0 a5a50001", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL read_hold: got v=%b d=%h expected 0 a5a50001", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int base_rsp, budget;
        logic [32:0] exp_rsp;
        PREADY = 1'b0; echo_mode = 1'b1; cmd_write = 1'b0;
        base_rsp = rsp_log.size();
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_addr = 8'h40 + 8'(i); cmd_wdata = 32'h0;
            checks++;
            if (cmd_ready !== (i < 5 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL fill_ready_%0d: got %b expected %b", i, cmd_ready, (i < 5 ? 1'b1 : 1'b0));
            end
            if (i < 5) tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 8'h40) begin
            errors++;
            $display("FAIL fill_inflight: got busy=%b en=%b addr=%h expected 1 1 40", busy, PENABLE, PADDR);
        end
        PREADY = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready_hold: got ready=%b v=%b expected 0 1", cmd_ready, rsp_valid);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b1 || PADDR !== 8'h41) begin
            errors++;
            $display("FAIL fill_ready_reassert: got ready=%b sel=%b addr=%h expected 1 1 41",
                     cmd_ready, PSEL, PADDR);
        end
        budget = 0;
        while (rsp_log.size() - base_rsp < 5 && budget < 60) begin
            tick();
            budget++;
        end
        tick();
        checks++;
        if (rsp_log.size() - base_rsp !== 5) begin
            errors++;
            $display("FAIL fill_rsp_count: got %0d expected 5", rsp_log.size() - base_rsp);
        end
        for (int i = 0; i < 5; i++) begin
            exp_rsp = {1'b0, 24'h5A5A5A, 8'h40 + 8'(i)};
            checks++;
            if (base_rsp + i >= rsp_log.size() || rsp_log[base_rsp + i] !== exp_rsp) begin
                errors++;
                $display("FAIL fill_order_%0d: got %h expected %h", i,
                         (base_rsp + i < rsp_log.size()) ? rsp_log[base_rsp + i] : 33'h0, exp_rsp);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_idle: got busy=%b expected 0", busy);
        end
        PREADY = 1'b0; echo_mode = 1'b0;
    endtask

    task automatic test_timeout();
        int acc, budget;
        PREADY = 1'b0; echo_mode = 1'b0; prdata_val = 32'hCAFE_F00D;
        cmd_write = 1'b0; cmd_valid = 1'b1; cmd_addr = 8'h30;
        tick();
        cmd_addr = 8'h31;
        tick();
        cmd_valid = 1'b0;
        acc = 0; budget = 0;
        while (rsp_valid !== 1'b1 && budget < 40) begin
            tick();
            budget++;
            if (PENABLE === 1'b1) acc++;
        end
        checks++;
        if (acc !== 16) begin
            errors++;
            $display("FAIL timeout_len: got %0d expected 16", acc);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp: got v=%b e=%b d=%h sel=%b expected 1 1 0 0",
                     rsp_valid, rsp_err, rsp_rdata, PSEL);
        end
        PREADY = 1'b1; echo_mode = 1'b1;
        budget = 0;
        tick();
        while (rsp_valid !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h5A5A_5A31) begin
            errors++;
            $display("FAIL timeout_next: got v=%b e=%b d=%h expected 1 0 5a5a5a31",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
        PREADY = 1'b0; echo_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base_rsp, base_psel;
        PREADY = 1'b0; cmd_write = 1'b1; cmd_wdata = 32'h7777_0000;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_addr = 8'h60 + 8'(i);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (PENABLE !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_access: got en=%b busy=%b expected 1 1", PENABLE, busy);
        end
        base_rsp = rsp_log.size();
        PRESETn = 1'b0;
        tick();
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: got sel=%b en=%b v=%b ready=%b expected 0 0 0 0",
                     PSEL, PENABLE, rsp_valid, cmd_ready);
        end
        PRESETn = 1'b1; PREADY = 1'b1;
        base_psel = psel_cnt;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b0 || psel_cnt - base_psel !== 0 || rsp_log.size() - base_rsp !== 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got busy=%b psel=%0d rsp=%0d expected 0 0 0",
                     busy, psel_cnt - base_psel, rsp_log.size() - base_rsp);
        end
        PREADY = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0;
        cmd_wdata = 32'h0; PREADY = 1'b0; echo_mode = 1'b0; prdata_val = 32'h0;
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
